// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Non-shift ops finish in one cycle. Shifts are iterative by default and
// move one bit per cycle, so an op takes 1+amt cycles.
// Define ALU_FAST_SHIFT_EN to build a combinational barrel shifter instead.
// With that macro the SHIFT state and the amt counter are not built.
// The handshake protocol and the result values are the same in both builds.

package alu_types_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_ADD  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module alu_exec_unit
  import alu_types_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  aluop_t           aluop,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] DONE  = 2'b10;
`ifndef ALU_FAST_SHIFT_EN
  localparam logic [1:0] SHIFT = 2'b01;
`endif

  logic [1:0] state;
  logic       accept;

  // Single-cycle ops. Undefined opcodes fall through to zero.
  function automatic logic [WIDTH-1:0] alu_eval(input aluop_t op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic        [WIDTH-1:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      ALU_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  r = a << b[SW-1:0];
      ALU_SRL:  r = a >> b[SW-1:0];
      ALU_SRA:  r = sa >>> b[SW-1:0];
`endif
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  // zero is qualified by out_valid, so it reads 0 out of reset and after a flush.
  assign zero      = out_valid && (result == '0);
  // A flush blocks acceptance for the cycle it is asserted.
  assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN

  // State, result and handshake control. Every op completes in one cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      result <= alu_eval(aluop, port_a, port_b);
      state  <= DONE;
    end else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end

`else

  logic [SW-1:0]    amt;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] acc;
  logic             shift_left;
  logic             shift_arith;
  logic             is_shift;

  // Shift one bit. A right arithmetic shift replicates the sign bit.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic left,
                                                  input logic arith);
    if (left)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {arith & v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  assign shamt    = port_b[SW-1:0];
  assign is_shift = (aluop == ALU_SLL) || (aluop == ALU_SRL) || (aluop == ALU_SRA);

  // State, shift counter and result. A zero-amount shift skips the SHIFT state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      amt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      amt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_shift) begin
              amt <= shamt;
              if (shamt == '0) begin
                result <= port_a;
                state  <= DONE;
              end else begin
                state <= SHIFT;
              end
            end else begin
              result <= alu_eval(aluop, port_a, port_b);
              state  <= DONE;
            end
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          amt <= amt - 1'b1;
          if (amt == SW'(1)) begin
            result <= shift_step(acc, shift_left, shift_arith);
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift datapath: load the operand on accept, then step it while in SHIFT.
  always_ff @(posedge CLK) begin
    if (accept && is_shift) begin
      acc         <= port_a;
      shift_left  <= (aluop == ALU_SLL);
      shift_arith <= (aluop == ALU_SRA);
    end else if (state == SHIFT) begin
      acc <= shift_step(acc, shift_left, shift_arith);
    end
  end

`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver pushes the expected result on
// every accept; a monitor pops and compares whenever the output handshake fires.
module tb_alu_exec_unit;
  import alu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  aluop_t      aluop;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

`ifdef ALU_FAST_SHIFT_EN
  localparam int SHIFT_EXTRA = 0;
`else
  localparam int SHIFT_EXTRA = 1;
`endif

  alu_exec_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .port_a(port_a), .port_b(port_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    int          t;
  } exp_t;

  exp_t q[$];
  bit   head_seen = 0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: the results are plain arithmetic on the operands.
  // The expected latency is 1 cycle, plus the shift amount in the iterative build.
  function automatic exp_t model(input aluop_t op, input logic [31:0] a,
                                 input logic [31:0] b, input int t);
    exp_t        e;
    int          amt;
    logic [31:0] r;
    amt = int'(b[4:0]);
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      ALU_SLL:  r = a << amt;
      ALU_SRL:  r = a >> amt;
      ALU_SRA:  r = 32'($signed(a) >>> amt);
      default:  r = 32'd0;
    endcase
    e.res = r;
    e.z   = (r == 32'd0);
    e.t   = t;
    if ((op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA))
      e.lat = 1 + SHIFT_EXTRA * amt;
    else
      e.lat = 1;
    return e;
  endfunction

  // Drive one cycle. An accepted op pushes its expected result, from the model or from the values given.
  task automatic step(input bit v, input aluop_t op, input logic [31:0] a, input logic [31:0] b,
                      input bit ordy, input bit fl, input bit dir,
                      input logic [31:0] dres, input int dlat);
    exp_t e;
    in_valid = v; aluop = op; port_a = a; port_b = b; out_ready = ordy; flush = fl;
    @(negedge CLK);
    if (in_valid && in_ready) begin
      if (dir) begin
        e.res = dres; e.z = (dres == 32'd0); e.lat = dlat; e.t = cyc;
      end else begin
        e = model(op, a, b, cyc);
      end
      q.push_back(e);
    end
    @(posedge CLK);
    if (fl) begin
      q.delete();
      head_seen = 0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, ALU_ADD, 32'd0, 32'd0, 1, 0, 0, 32'd0, 0);
  endtask

  task automatic drain(input int limit);
    int n;
    in_valid = 0; out_ready = 1; flush = 0; n = 0;
    while ((q.size() != 0 || out_valid) && n < limit) begin
      @(posedge CLK); #1; n++;
    end
    check("drain_pending", 32'(q.size()), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: check the in_ready rule, the latency, and the result/zero at each output handshake.
  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      check("in_ready_rule", 32'(in_ready),
            32'(!flush && (!busy || (out_valid && out_ready))));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          if (!head_seen) begin
            head_seen = 1;
            check("latency", 32'(cyc - q[0].t), 32'(q[0].lat));
          end
          if (out_ready) begin
            e = q.pop_front();
            head_seen = 0;
            check("result", result, e.res);
            check("zero", 32'(zero), 32'(e.z));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    nRST = 0; in_valid = 0; aluop = ALU_ADD; port_a = 0; port_b = 0; flush = 0; out_ready = 0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge CLK); nRST = 1;
    @(posedge CLK); #1;

    // ADD wraps to zero.
    step(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1, 0, 1, 32'd0, 1);
    drain(10);
    // SRA by 31 replicates the sign bit.
    step(1, ALU_SRA, 32'h8000_0000, 32'd31, 1, 0, 1, 32'hFFFF_FFFF, 1 + 31 * SHIFT_EXTRA);
    drain(50);
    // Signed and unsigned compares.
    step(1, ALU_SLT,  32'hFFFF_FFFF, 32'd1, 1, 0, 1, 32'd1, 1);
    step(1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 1, 0, 1, 32'd0, 1);
    drain(10);
    // Shift amount 0 (b=32) passes port_a through in one cycle.
    step(1, ALU_SRL, 32'h1234_5678, 32'd32, 1, 0, 1, 32'h1234_5678, 1);
    drain(10);

    // Backpressure: SUB result held while a queued XOR waits.
    step(1, ALU_SUB, 32'd5, 32'd3, 0, 0, 1, 32'd2, 1);
    in_valid = 1; aluop = ALU_XOR; port_a = 32'hF0F0_0000; port_b = 32'h0FF0_00FF; out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, 32'd2);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge CLK); #1;
    end
    step(1, ALU_XOR, 32'hF0F0_0000, 32'h0FF0_00FF, 1, 0, 1, 32'hFF00_00FF, 1);
    drain(10);

    // Flush during an SLL by 20: no result may appear afterwards.
    step(1, ALU_SLL, 32'd1, 32'd20, 1, 0, 1, 32'h0010_0000, 1 + 20 * SHIFT_EXTRA);
    idle(4);
    in_valid = 1; aluop = ALU_ADD; port_a = 32'd1; port_b = 32'd1; out_ready = 0; flush = 1;
    @(negedge CLK);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge CLK); q.delete(); head_seen = 0; #1;
    flush = 0; in_valid = 0; out_ready = 1;
    @(negedge CLK);
    check("post_flush_out_valid", 32'(out_valid), 32'd0);
    check("post_flush_in_ready", 32'(in_ready), 32'd1);
    check("post_flush_busy", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    idle(30);

    // Async reset in the middle of an SRL while an undefined op is offered.
    step(1, ALU_SRL, 32'hFFFF_0000, 32'd25, 1, 0, 1, 32'h0000_007F, 1 + 25 * SHIFT_EXTRA);
    idle(2);
    in_valid = 1; aluop = aluop_t'(4'hF);
    #2 nRST = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", 32'(zero), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete(); head_seen = 0; in_valid = 0;
    @(negedge CLK); nRST = 1;
    @(posedge CLK); #1;
    step(1, aluop_t'(4'hB), 32'd5, 32'd7, 1, 0, 1, 32'd0, 1);
    step(1, aluop_t'(4'hF), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 32'd0, 1);
    drain(10);

    // Random traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      bit          v, ordy, fl;
      aluop_t      op;
      logic [31:0] a, b;
      v    = ($urandom_range(0, 3) != 0);
      op   = aluop_t'(4'($urandom_range(0, 15)));
      a    = pick();
      b    = ($urandom_range(0, 1) == 0) ? pick() : 32'($urandom_range(0, 31));
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 49) == 0);
      if (fl) ordy = 0;
      step(v, op, a, b, ordy, fl, 0, 32'd0, 0);
    end
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
